// File: rtl/gate_pkg.sv
// gate_pkg: op encodings and a width helper shared by the gate array.
// Ops 0..5 reduce across all operands; 6/7 use operand 0 only.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  function automatic int ones_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// gate_pipe_stage: one elastic stage (valid bit + payload register).
// Ports: in_valid/in_ready/in_data upstream, out_* downstream.
module gate_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Load when empty or when the current contents leave this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/gate_array.sv
// gate_array: NUM_IN x WIDTH bitwise logic unit, 2-stage valid/ready pipe.
// Ports: in_valid/in_ready/in_data/in_op, out_valid/out_ready/out_data/out_ones/out_op, txn_count.
module gate_array
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_IN*WIDTH-1:0]    in_data,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [ones_w(WIDTH)-1:0]   out_ones,
  output logic [2:0]                 out_op,
  output logic [CNT_W-1:0]           txn_count
);

  localparam int OW = ones_w(WIDTH);
  localparam int P1 = WIDTH + 3;
  localparam int P2 = WIDTH + 3 + OW;

  logic [WIDTH-1:0] and_r, or_r, xor_r, op0, res;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      and_r = and_r & in_data[k*WIDTH +: WIDTH];
      or_r  = or_r  | in_data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
    end
    op0 = in_data[WIDTH-1:0];
    res = '0;
    case (in_op)
      OP_AND:  res = and_r;
      OP_OR:   res = or_r;
      OP_XOR:  res = xor_r;
      OP_NAND: res = ~and_r;
      OP_NOR:  res = ~or_r;
      OP_XNOR: res = ~xor_r;
      OP_NOT:  res = ~op0;
      OP_PASS: res = op0;
      default: res = '0;
    endcase
  end

  logic          s1_valid, s2_ready;
  logic [P1-1:0] s1_data;
  logic [P2-1:0] s2_in, s2_data;
  logic [OW-1:0] ones;

  gate_pipe_stage #(.W(P1)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, res}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++)
      ones = ones + OW'(s1_data[i]);
  end

  assign s2_in = {ones, s1_data};

  gate_pipe_stage #(.W(P2)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_data = s2_data[WIDTH-1:0];
  assign out_op   = s2_data[WIDTH+2:WIDTH];
  assign out_ones = s2_data[P2-1:P1];

  always_ff @(posedge clk) begin
    if (rst)
      txn_count <= '0;
    else if (out_valid && out_ready)
      txn_count <= txn_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_gate_array.sv
// tb_gate_array: randomized + directed bench for gate_array with a
// per-bit counting reference model and a scoreboard queue.
module tb_gate_array;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic            clk = 0;
  logic            rst = 1;
  logic            in_valid = 0;
  logic            in_ready;
  logic [N*W-1:0]  in_data = '0;
  logic [2:0]      in_op = '0;
  logic            out_valid;
  logic            out_ready = 1;
  logic [W-1:0]    out_data;
  logic [3:0]      out_ones;
  logic [2:0]      out_op;
  logic [CW-1:0]   txn_count;

  int n_pass = 0;
  int n_total = 0;
  int mode = 0;
  logic [10:0] q[$];
  logic [CW-1:0] exp_cnt = '0;

  gate_array #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ones  (out_ones),
    .out_op    (out_op),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Per-bit count of ones across operands decides every reduction.
  function automatic logic [W-1:0] model(input logic [N*W-1:0] d,
                                         input logic [2:0] op);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int c = 0;
      for (int k = 0; k < N; k++) c += int'(d[k*W+i]);
      case (op)
        3'd0: r[i] = (c == N);
        3'd1: r[i] = (c > 0);
        3'd2: r[i] = (c % 2 == 1);
        3'd3: r[i] = !(c == N);
        3'd4: r[i] = !(c > 0);
        3'd5: r[i] = !(c % 2 == 1);
        3'd6: r[i] = !d[i];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  always begin
    @(posedge clk);
    #2;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: outputs must match the oldest accepted input.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      chk("txn_count", 32'(txn_count), 32'(exp_cnt));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL spurious out_valid: data %0h, nothing pending", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(q[0][7:0]));
          chk("out_ones", 32'(out_ones), $countones(q[0][7:0]));
          chk("out_op", 32'(out_op), 32'(q[0][10:8]));
          if (out_ready) begin
            void'(q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back({in_op, model(in_data, in_op)});
    end
  end

  task automatic send(input logic [N*W-1:0] d, input logic [2:0] op);
    logic acc;
    int i;
    in_valid = 1;
    in_data = d;
    in_op = op;
    acc = 0;
    for (i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL send timeout: in_ready stuck 0");
    end
    in_valid = 0;
  endtask

  task automatic drain();
    mode = 0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_txn", 32'(txn_count), 0);

    // AND F0,3C (other operands all-ones leave AND unchanged).
    send({8'hFF, 8'hFF, 8'h3C, 8'hF0}, 3'd0);
    @(posedge clk); #1;
    chk("and_valid", 32'(out_valid), 1);
    chk("and_data", 32'(out_data), 32'h30);
    chk("and_ones", 32'(out_ones), 2);
    chk("and_op", 32'(out_op), 0);
    @(posedge clk); #1;
    chk("and_txn", 32'(txn_count), 1);

    send({8'h00, 8'h01, 8'h0F, 8'hFF}, 3'd2);
    @(posedge clk); #1;
    chk("xor_data", 32'(out_data), 32'hF1);
    chk("xor_ones", 32'(out_ones), 5);
    chk("xor_op", 32'(out_op), 2);
    drain();

    for (int op = 0; op < 6; op++)
      for (int v = 0; v < 4; v++)
        send({16'h0, 7'h0, 1'(v >> 1), 7'h0, 1'(v)}, 3'(op));
    drain();

    mode = 2;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send({$urandom()}, 3'($urandom_range(0, 7)));
    end
    drain();

    // Backpressure: two accepted, third refused.
    mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1;
    in_data = {$urandom()}; in_op = 3'd1;
    @(negedge clk); chk("bp_rdy0", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_data = {$urandom()}; in_op = 3'd4;
    @(negedge clk); chk("bp_rdy1", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_data = {$urandom()}; in_op = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("bp_full", 32'(in_ready), 0);
      chk("bp_held", 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    mode = 0;
    @(negedge clk); chk("bp_release", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    drain();

    // Throughput: back-to-back with ready held high.
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = {$urandom()};
      in_op = 3'($urandom_range(0, 7));
      @(negedge clk); chk("tput_rdy", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    mode = 2;
    for (int i = 0; i < 20; i++)
      send({$urandom()}, 3'($urandom_range(0, 7)));
    drain();

    // Reset with both stages full.
    mode = 1;
    send({$urandom()}, 3'd2);
    send({$urandom()}, 3'd5);
    @(negedge clk); chk("full_pre", 32'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mode = 0;
    chk("rst2_valid", 32'(out_valid), 0);
    chk("rst2_rdy", 32'(in_ready), 1);
    chk("rst2_txn", 32'(txn_count), 0);

    // 17 transfers on a 4-bit counter wrap to 1.
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++)
      send({$urandom()}, 3'($urandom_range(0, 7)));
    drain();
    chk("wrap_txn", 32'(txn_count), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
